// File: rtl/serial_complementor_pkg.sv
// Shared types for the chunk-serial complement unit: operation modes and FSM states.
// Optional overflow detection is enabled by defining SERIAL_COMPL_OVF_EN.
package serial_complementor_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_ONES = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // True when the operation reduces to "invert and add one".
    function automatic logic negate_path(input mode_e mode, input logic sign);
        return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
    endfunction

endpackage

// File: rtl/serial_complementor_if.sv
// Operand/result valid-ready bundle for serial_complementor.
interface serial_complementor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_ovf;

    modport master (
        output in_valid, in_mode, in_a, out_ready,
        input  in_ready, out_valid, out_res, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_a, out_ready,
        output in_ready, out_valid, out_res, out_ovf
    );
endinterface

// File: rtl/compl_chunk_slice.sv
// One CHUNK-wide step of the complement carry chain: {cout, r} = (chunk ^ mask) + cin.
module compl_chunk_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic [CHUNK-1:0] mask,
    input  logic             cin,
    output logic [CHUNK-1:0] r,
    output logic             cout
);
    always_comb begin
        {cout, r} = {1'b0, chunk ^ mask} + {{CHUNK{1'b0}}, cin};
    end
endmodule

// File: rtl/serial_complementor.sv
// Chunk-serial pass/negate/abs/ones' complement unit, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_COMPL_OVF_EN to flag negation of the most negative operand on out_ovf.
module serial_complementor
    import serial_complementor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_complementor_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               mask_q, mask_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   slice_r;
    logic               slice_cout;
    logic [WIDTH-1:0]   work_shift;
    logic               ovf_det;
    logic               neg_sel;
    mode_e              mode_in;

    compl_chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .chunk (work_q[CHUNK-1:0]),
        .mask  ({CHUNK{mask_q}}),
        .cin   (carry_q),
        .r     (slice_r),
        .cout  (slice_cout)
    );

    // Operand drains from the bottom while result chunks enter at the top,
    // so after NCHUNK steps the same register holds the finished result.
    generate
        if (NCHUNK == 1) begin : g_single
            assign work_shift = slice_r;
        end else begin : g_multi
            assign work_shift = {slice_r, work_q[WIDTH-1:CHUNK]};
        end
    endgenerate

`ifdef SERIAL_COMPL_OVF_EN
    // Carry into the result MSB recovered as r_msb ^ operand_msb, compared with carry out.
    assign ovf_det = (work_q[CHUNK-1] ^ mask_q ^ slice_r[CHUNK-1]) ^ slice_cout;
`else
    assign ovf_det = 1'b0;
`endif

    assign mode_in = mode_e'(bus.in_mode);
    assign neg_sel = negate_path(mode_in, bus.in_a[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mask_d  = mask_q;
        work_d  = work_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_a;
                    mask_d  = neg_sel || (mode_in == MODE_ONES);
                    carry_d = neg_sel;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d  = work_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    res_d   = work_shift;
                    ovf_d   = ovf_det;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mask_q  <= 1'b0;
            work_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mask_q  <= mask_d;
            work_q  <= work_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_res   = res_q;
    assign bus.out_ovf   = ovf_q;

endmodule
